// File: rtl/sqrt_share_arb_if.sv
// Bundle of the requester, sqrt-unit and response channels around sqrt_share_arb.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sqrt_share_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
);
    localparam int unsigned RW = (DW + DW % 2) / 2;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;

    logic [DW-1:0]      sq_din;
    logic               sq_din_valid;
    logic               sq_busy;
    logic [RW-1:0]      sq_root;
    logic [DW-2:0]      sq_rem;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [RW-1:0]      rsp_root;
    logic [DW-2:0]      rsp_rem;
    logic               rsp_err;
    logic               err_sticky;

    modport slave (
        input  req_valid, req_data, sq_busy, sq_root, sq_rem, rsp_ready,
        output req_ready, sq_din, sq_din_valid, rsp_valid, rsp_id, rsp_root, rsp_rem,
               rsp_err, err_sticky
    );

    modport master (
        output req_valid, req_data, sq_busy, sq_root, sq_rem, rsp_ready,
        input  req_ready, sq_din, sq_din_valid, rsp_valid, rsp_id, rsp_root, rsp_rem,
               rsp_err, err_sticky
    );
endinterface

// File: rtl/sqrt_share_arb.sv
// Round-robin arbiter sharing one iterative square-root unit among NREQ requesters,
// with start/busy sequencing, a backpressured response channel and a run watchdog.
module sqrt_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned TMO  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    sqrt_share_arb_if.slave  bus
);
    localparam int unsigned RW = (DW + DW % 2) / 2;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StRun, StResp} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [DW-1:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic [RW-1:0] root_q, root_d;
    logic [DW-2:0] rem_q, rem_d;
    logic          err_q, err_d;
    logic          sticky_q, sticky_d;

    logic          hi_found, lo_found;
    logic [IW-1:0] hi_idx, lo_idx, gnt_idx;
    logic          gnt_any;

    // First valid at or above the pointer wins; otherwise the lowest valid (wrap-around).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(i);
                end
                if (!hi_found && (IW'(i) >= ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
    end

    assign gnt_idx = hi_found ? hi_idx : lo_idx;
    assign gnt_any = (state_q == StIdle) && lo_found && !bus.sq_busy;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        root_d   = root_q;
        rem_d    = rem_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    op_d    = bus.req_data[gnt_idx*DW +: DW];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                seen_d  = 1'b0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.sq_busy) begin
                    seen_d = 1'b1;
                end
                // A busy period that has ended means the result is ready; it beats the watchdog.
                if (seen_q && !bus.sq_busy) begin
                    root_d  = bus.sq_root;
                    rem_d   = bus.sq_rem;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    root_d   = '0;
                    rem_d    = '0;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            root_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            root_q   <= root_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.req_ready    = gnt_any ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign bus.sq_din       = op_q;
    assign bus.sq_din_valid = (state_q == StIssue);
    assign bus.rsp_valid    = (state_q == StResp);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_root     = root_q;
    assign bus.rsp_rem      = rem_q;
    assign bus.rsp_err      = err_q;
    assign bus.err_sticky   = sticky_q;
endmodule

// File: tb/tb_sqrt_share_arb.sv
// Bench for sqrt_share_arb: a behavioural sqrt unit plus a transaction-level reference
// model (round-robin order, fixed service latency, integer square root) checked every cycle.
module tb_sqrt_share_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned TMO  = 24;
    localparam int unsigned RW   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sqrt_share_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

    sqrt_share_arb #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned lo = 0;
        longint unsigned hi = 65536;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Behavioural sqrt unit: busy rises the cycle after the start pulse for RW cycles.
    bit          dead_unit = 1'b0;
    bit          ext_busy  = 1'b0;
    logic        u_busy;
    logic [4:0]  u_cnt;
    logic [15:0] u_root = '0;
    logic [30:0] u_rem  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_busy <= 1'b0;
            u_cnt  <= '0;
        end else if (u_cnt != 0) begin
            u_cnt  <= u_cnt - 5'd1;
            u_busy <= (u_cnt > 5'd1);
        end else if (bus.sq_din_valid && !dead_unit) begin
            u_busy <= 1'b1;
            u_cnt  <= 5'(RW);
            u_root <= 16'(isqrt(64'(bus.sq_din)));
            u_rem  <= 31'(64'(bus.sq_din) - isqrt(64'(bus.sq_din)) * isqrt(64'(bus.sq_din)));
        end
    end

    assign bus.sq_busy = u_busy | ext_busy;
    assign bus.sq_root = u_root;
    assign bus.sq_rem  = u_rem;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model state
    bit              m_busy   = 1'b0;
    int              m_ptr    = 0;
    int              m_id     = 0;
    int              m_acc    = -10;
    int              m_due    = 0;
    logic [31:0]     m_op     = '0;
    longint unsigned m_root   = 0;
    longint unsigned m_rem    = 0;
    bit              m_err    = 1'b0;
    bit              m_sticky = 1'b0;

    // Observations
    bit              rand_mode      = 1'b0;
    bit              drop_on_accept = 1'b1;
    int              acc_idx        = -1;
    int              last_acc       = -1;
    int              acc_cyc        = 0;
    int              hs_cnt         = 0;
    int              start_cnt      = 0;
    bit              prev_valid     = 1'b0;
    bit              new_valid      = 1'b0;
    int              valid_cyc      = 0;
    longint unsigned v_id, v_root, v_rem, v_err;
    int              obs_id[$];
    longint unsigned obs_root[$];
    longint unsigned obs_rem[$];

    function automatic logic [31:0] rand_op();
        int unsigned r;
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return 32'($urandom_range(0, 255));
            2: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
            default: begin
                r = $urandom_range(0, 65535);
                return 32'(r * r);
            end
        endcase
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                bus.req_valid[i]          = 1'b1;
                bus.req_data[i*DW +: DW]  = rand_op();
            end
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        if (!m_busy) begin
            dead_unit = ($urandom_range(0, 7) == 0);
            ext_busy  = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_ready;
        int              exp_g;
        bit              exp_v, exp_start;
        @(negedge clk);
        exp_ready = '0;
        exp_g     = -1;
        if (!m_busy && bus.req_valid != '0 && !bus.sq_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (exp_g < 0 && bus.req_valid[idx]) exp_g = idx;
            end
            exp_ready[exp_g] = 1'b1;
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        exp_start = m_busy && (cyc == m_acc + 1);
        check("sq_din_valid", 64'(bus.sq_din_valid), 64'(exp_start));
        if (exp_start) check("sq_din", 64'(bus.sq_din), 64'(m_op));
        exp_v = m_busy && (cyc >= m_due);
        if (exp_v && m_err) m_sticky = 1'b1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
        check("err_sticky", 64'(bus.err_sticky), 64'(m_sticky));
        if (exp_v) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            check("rsp_root", 64'(bus.rsp_root), m_root);
            check("rsp_rem", 64'(bus.rsp_rem), m_rem);
            check("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        end
        if (bus.sq_din_valid) start_cnt++;
        new_valid = bus.rsp_valid && !prev_valid;
        if (new_valid) begin
            valid_cyc = cyc;
            v_id      = 64'(bus.rsp_id);
            v_root    = 64'(bus.rsp_root);
            v_rem     = 64'(bus.rsp_rem);
            v_err     = 64'(bus.rsp_err);
        end
        prev_valid = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
            hs_cnt++;
            obs_id.push_back(int'(bus.rsp_id));
            obs_root.push_back(64'(bus.rsp_root));
            obs_rem.push_back(64'(bus.rsp_rem));
        end
        acc_idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) acc_idx = i;
        end
        if (acc_idx >= 0) begin
            last_acc = acc_idx;
            acc_cyc  = cyc;
        end
        if (exp_v && bus.rsp_ready) begin
            m_busy = 1'b0;
        end else if (exp_g >= 0) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_id   = exp_g;
            m_ptr  = (exp_g + 1) % NREQ;
            m_op   = bus.req_data[exp_g*DW +: DW];
            m_err  = dead_unit;
            m_due  = cyc + (dead_unit ? int'(TMO) + 2 : int'(RW) + 3);
            m_root = dead_unit ? 0 : isqrt(64'(m_op));
            m_rem  = dead_unit ? 0 : 64'(m_op) - m_root * m_root;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (acc_idx >= 0 && drop_on_accept) bus.req_valid[acc_idx] = 1'b0;
        if (rand_mode) randomize_inputs();
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            ok = new_valid;
        end
        check("wait_rsp_valid", 64'(ok), 64'(1));
    endtask

    task automatic wait_accept(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            ok = (acc_idx >= 0);
        end
        check("wait_accept", 64'(ok), 64'(1));
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int n = 0; n < budget && hs_cnt < target; n++) step();
        check("wait_handshake", 64'(hs_cnt >= target), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
        check({tag, "_sq_din_valid"}, 64'(bus.sq_din_valid), 64'(0));
        check({tag, "_sq_din"}, 64'(bus.sq_din), 64'(0));
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
        check({tag, "_rsp_root"}, 64'(bus.rsp_root), 64'(0));
        check({tag, "_rsp_rem"}, 64'(bus.rsp_rem), 64'(0));
        check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
        check({tag, "_err_sticky"}, 64'(bus.err_sticky), 64'(0));
    endtask

    int              exp_ids[5]   = '{0, 1, 2, 3, 0};
    longint unsigned exp_roots[5] = '{4, 65535, 0, 1, 4};
    longint unsigned exp_rems[5]  = '{1, 131070, 0, 1, 1};
    int              hs0, st0;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Busy unit blocks any grant
        ext_busy      = 1'b1;
        bus.req_valid = 4'b0101;
        repeat (3) step();
        check("busy_no_start", 64'(start_cnt), 64'(0));
        bus.req_valid = '0;
        ext_busy      = 1'b0;
        step();

        // All requesters valid continuously
        bus.req_data   = {32'd2, 32'd0, 32'hFFFF_FFFF, 32'd17};
        drop_on_accept = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 4'b1111;
        hs0 = hs_cnt;
        obs_id.delete();
        obs_root.delete();
        obs_rem.delete();
        wait_hs(hs0 + 5, 200);
        bus.req_valid  = '0;
        drop_on_accept = 1'b1;
        for (int k = 0; k < 5 && k < obs_id.size(); k++) begin
            check($sformatf("rr_id%0d", k), 64'(obs_id[k]), 64'(exp_ids[k]));
            check($sformatf("rr_root%0d", k), obs_root[k], exp_roots[k]);
            check($sformatf("rr_rem%0d", k), obs_rem[k], exp_rems[k]);
        end

        // Pointer wrap: serve 3, then 1 and 3 compete
        bus.req_data[3*DW +: DW] = rand_op();
        bus.req_valid = 4'b1000;
        wait_hs(hs_cnt + 1, 60);
        bus.req_data[1*DW +: DW] = rand_op();
        bus.req_data[3*DW +: DW] = rand_op();
        bus.req_valid = 4'b1010;
        wait_accept(10);
        check("wrap_grant", 64'(last_acc), 64'(1));
        wait_hs(hs_cnt + 2, 100);

        // Single request
        bus.req_data[2*DW +: DW] = 32'd1000000;
        bus.req_valid = 4'b0100;
        wait_valid(40);
        check("single_lat", 64'(valid_cyc - acc_cyc), 64'(19));
        check("single_id", v_id, 64'(2));
        check("single_root", v_root, 64'(1000));
        check("single_rem", v_rem, 64'(0));
        check("single_err", v_err, 64'(0));
        repeat (2) step();

        // Backpressure
        bus.rsp_ready = 1'b0;
        bus.req_data[0 +: DW]  = rand_op();
        bus.req_data[DW +: DW] = rand_op();
        bus.req_valid = 4'b0011;
        wait_valid(40);
        check("bp_id", v_id, 64'(0));
        st0 = start_cnt;
        repeat (10) step();
        check("bp_no_start", 64'(start_cnt - st0), 64'(0));
        hs0 = hs_cnt;
        bus.rsp_ready = 1'b1;
        repeat (3) step();
        check("bp_one_hs", 64'(hs_cnt - hs0), 64'(1));
        wait_hs(hs0 + 2, 40);

        // Watchdog
        dead_unit = 1'b1;
        bus.req_data[0 +: DW] = 32'd99;
        bus.req_valid = 4'b0001;
        wait_valid(60);
        check("wd_lat", 64'(valid_cyc - acc_cyc), 64'(TMO + 2));
        check("wd_err", v_err, 64'(1));
        check("wd_root", v_root, 64'(0));
        check("wd_rem", v_rem, 64'(0));
        step();
        dead_unit = 1'b0;
        bus.req_data[2*DW +: DW] = 32'd150;
        bus.req_valid = 4'b0100;
        wait_valid(40);
        check("wd_after_err", v_err, 64'(0));
        check("wd_after_root", v_root, 64'(12));
        check("wd_after_rem", v_rem, 64'(6));
        check("wd_sticky_held", 64'(bus.err_sticky), 64'(1));
        repeat (2) step();

        // Reset during RUN
        bus.req_data[DW +: DW] = rand_op();
        bus.req_valid = 4'b0010;
        wait_accept(10);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_busy   = 1'b0;
        m_ptr    = 0;
        m_sticky = 1'b0;
        prev_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_data[0 +: DW]    = 32'd49;
        bus.req_data[2*DW +: DW] = rand_op();
        bus.req_valid = 4'b0101;
        wait_accept(10);
        check("post_rst_grant", 64'(last_acc), 64'(0));
        wait_valid(40);
        check("post_rst_root", v_root, 64'(7));
        wait_hs(hs_cnt + 1, 40);

        // Randomised traffic
        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode     = 1'b0;
        ext_busy      = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
